// File: rtl/ped_crossing_ctrl.sv
// Pedestrian signal stage for a 4-way intersection. It takes the registered
// vehicle light vectors and drives WALK / DON'T WALK heads and a clearance
// countdown for the NS and EW crosswalks. Each crosswalk is an identical
// channel FSM. A sticky fault flag forces both heads to DON'T WALK whenever
// the light vectors are illegal.
//
// Handshake note: there is no valid/ready traffic in this block. Buttons are
// level inputs sampled on every edge, and every output is a registered level.

module ped_channel #(
  parameter int WALK_CYC  = 8,
  parameter int CLEAR_CYC = 6,
  parameter int FLASH_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] par_light_i,    // light of traffic parallel to this crosswalk
  input  logic [2:0] cross_light_i,  // light of traffic crossing this crosswalk
  input  logic       btn_i,
  input  logic       hold_i,         // fault seen now or earlier: force idle
  output logic       walk_o,
  output logic       dont_walk_o,
  output logic [7:0] cnt_o,
  output logic       req_o,          // request latch, exposed for checking
  output logic [1:0] state_o         // FSM state, exposed for checking
);

  localparam int WW = (WALK_CYC  > 1) ? $clog2(WALK_CYC)  : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [WW-1:0] WALK_LAST  = WW'(WALK_CYC - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
  localparam logic [7:0]    CLEAR_INIT = 8'(CLEAR_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] walk_cnt_q, walk_cnt_d;
  logic [7:0]    clr_cnt_q, clr_cnt_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_q, flash_d;       // dont_walk level while in CLEAR
  logic          req_q, req_d;
  logic          walk_q, walk_d;
  logic          dont_walk_q, dont_walk_d;
  logic [7:0]    cnt_q, cnt_d;

  logic safe;
  logic enter_walk;

  assign safe = (par_light_i == 3'b001) && (cross_light_i == 3'b100);

  // Next-state, counters, request latch and registered head outputs.
  always_comb begin
    state_d     = state_q;
    walk_cnt_d  = walk_cnt_q;
    clr_cnt_d   = clr_cnt_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    enter_walk  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_q && safe) begin
          state_d    = ST_WALK;
          walk_cnt_d = '0;
          enter_walk = 1'b1;
        end
      end
      ST_WALK: begin
        if (!safe) begin
          state_d = ST_IDLE;
        end else if (walk_cnt_q == WALK_LAST) begin
          // Flash phase restarts here so DON'T WALK is always on at entry.
          state_d     = ST_CLEAR;
          clr_cnt_d   = CLEAR_INIT;
          flash_cnt_d = '0;
          flash_d     = 1'b1;
        end else begin
          walk_cnt_d = walk_cnt_q + 1'b1;
        end
      end
      ST_CLEAR: begin
        if (!safe) begin
          state_d = ST_IDLE;
        end else if (clr_cnt_q == 8'd1) begin
          state_d = ST_DONE;
        end else begin
          clr_cnt_d = clr_cnt_q - 8'd1;
          if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_d = '0;
            flash_d     = ~flash_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Waiting for the end of this green prevents a second walk in it.
        if (par_light_i != 3'b001) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (hold_i) begin
      state_d    = ST_IDLE;
      enter_walk = 1'b0;
    end

    // A press on the WALK-entry edge is a new request and must survive.
    if (hold_i)          req_d = 1'b0;
    else if (btn_i)      req_d = 1'b1;
    else if (enter_walk) req_d = 1'b0;
    else                 req_d = req_q;

    walk_d      = (state_d == ST_WALK);
    cnt_d       = (state_d == ST_CLEAR) ? clr_cnt_d : 8'd0;
    dont_walk_d = (state_d == ST_CLEAR) ? flash_d : (state_d != ST_WALK);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      walk_cnt_q  <= '0;
      clr_cnt_q   <= '0;
      flash_cnt_q <= '0;
      flash_q     <= 1'b1;
      req_q       <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      walk_cnt_q  <= walk_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      req_q       <= req_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      cnt_q       <= cnt_d;
    end
  end

  assign walk_o      = walk_q;
  assign dont_walk_o = dont_walk_q;
  assign cnt_o       = cnt_q;
  assign req_o       = req_q;
  assign state_o     = state_q;

endmodule

module ped_crossing_ctrl #(
  parameter int WALK_CYC  = 8,
  parameter int CLEAR_CYC = 6,
  parameter int FLASH_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ns_light,
  input  logic [2:0] ew_light,
  input  logic       ped_btn_ns,
  input  logic       ped_btn_ew,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic       dont_walk_ns,
  output logic       dont_walk_ew,
  output logic [7:0] cnt_ns,
  output logic [7:0] cnt_ew,
  output logic       fault,
  output logic [1:0] dbg_state_ns,  // 0 IDLE, 1 WALK, 2 CLEAR, 3 DONE
  output logic [1:0] dbg_state_ew,
  output logic       dbg_req_ns,
  output logic       dbg_req_ew
);

  logic fault_q, fault_d;
  logic fault_cond;
  logic ns_onehot, ew_onehot;
  logic hold;

  assign ns_onehot  = (ns_light == 3'b001) || (ns_light == 3'b010) || (ns_light == 3'b100);
  assign ew_onehot  = (ew_light == 3'b001) || (ew_light == 3'b010) || (ew_light == 3'b100);
  assign fault_cond = !ns_onehot || !ew_onehot || (!ns_light[2] && !ew_light[2]);
  assign fault_d    = fault_q | fault_cond;
  // Channels react on the same edge the fault is first seen.
  assign hold       = fault_d;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault = fault_q;

  ped_channel #(
    .WALK_CYC (WALK_CYC),
    .CLEAR_CYC(CLEAR_CYC),
    .FLASH_DIV(FLASH_DIV)
  ) u_ns (
    .clk          (clk),
    .reset        (reset),
    .par_light_i  (ns_light),
    .cross_light_i(ew_light),
    .btn_i        (ped_btn_ns),
    .hold_i       (hold),
    .walk_o       (walk_ns),
    .dont_walk_o  (dont_walk_ns),
    .cnt_o        (cnt_ns),
    .req_o        (dbg_req_ns),
    .state_o      (dbg_state_ns)
  );

  ped_channel #(
    .WALK_CYC (WALK_CYC),
    .CLEAR_CYC(CLEAR_CYC),
    .FLASH_DIV(FLASH_DIV)
  ) u_ew (
    .clk          (clk),
    .reset        (reset),
    .par_light_i  (ew_light),
    .cross_light_i(ns_light),
    .btn_i        (ped_btn_ew),
    .hold_i       (hold),
    .walk_o       (walk_ew),
    .dont_walk_o  (dont_walk_ew),
    .cnt_o        (cnt_ew),
    .req_o        (dbg_req_ew),
    .state_o      (dbg_state_ew)
  );

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with default parameters
// (WALK_CYC=8, CLEAR_CYC=6, FLASH_DIV=2). Inputs change and outputs are
// sampled on the falling edge; the design acts on the rising edge.

module tb_ped_crossing_ctrl;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam int S_IDLE  = 0;
  localparam int S_WALK  = 1;
  localparam int S_CLEAR = 2;
  localparam int S_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ns_light, ew_light;
  logic       ped_btn_ns, ped_btn_ew;
  logic       walk_ns, walk_ew, dont_walk_ns, dont_walk_ew;
  logic [7:0] cnt_ns, cnt_ew;
  logic       fault;
  logic [1:0] dbg_state_ns, dbg_state_ew;
  logic       dbg_req_ns, dbg_req_ew;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_cnt[6] = '{6, 5, 4, 3, 2, 1};
  int exp_dw[6]  = '{1, 1, 0, 0, 1, 1};

  // Clock generation.
  always #5 clk = ~clk;

  ped_crossing_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .ped_btn_ns  (ped_btn_ns),
    .ped_btn_ew  (ped_btn_ew),
    .walk_ns     (walk_ns),
    .walk_ew     (walk_ew),
    .dont_walk_ns(dont_walk_ns),
    .dont_walk_ew(dont_walk_ew),
    .cnt_ns      (cnt_ns),
    .cnt_ew      (cnt_ew),
    .fault       (fault),
    .dbg_state_ns(dbg_state_ns),
    .dbg_state_ew(dbg_state_ew),
    .dbg_req_ns  (dbg_req_ns),
    .dbg_req_ew  (dbg_req_ew)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_idle_all(input string tag);
    check({tag, " walk_ns"}, int'(walk_ns), 0);
    check({tag, " walk_ew"}, int'(walk_ew), 0);
    check({tag, " dw_ns"}, int'(dont_walk_ns), 1);
    check({tag, " dw_ew"}, int'(dont_walk_ew), 1);
    check({tag, " cnt_ns"}, int'(cnt_ns), 0);
    check({tag, " cnt_ew"}, int'(cnt_ew), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    ns_light   = RED;
    ew_light   = RED;
    ped_btn_ns = 1'b0;
    ped_btn_ew = 1'b0;
    do_reset();

    // Reset values.
    check_idle_all("rst");
    check("rst fault", int'(fault), 0);
    check("rst req_ns", int'(dbg_req_ns), 0);
    check("rst st_ns", int'(dbg_state_ns), S_IDLE);

    // Basic NS walk cycle.
    ns_light = GRN;
    step();
    ped_btn_ns = 1'b1;
    step();
    ped_btn_ns = 1'b0;
    check("t1 req latched", int'(dbg_req_ns), 1);
    check("t1 walk not yet", int'(walk_ns), 0);
    step();
    check("t1 req cleared", int'(dbg_req_ns), 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1 walk%0d", i), int'(walk_ns), 1);
      check($sformatf("t1 dw%0d", i), int'(dont_walk_ns), 0);
      check($sformatf("t1 cnt_w%0d", i), int'(cnt_ns), 0);
      check($sformatf("t1 ew%0d", i), int'(walk_ew), 0);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1 clr_walk%0d", i), int'(walk_ns), 0);
      check($sformatf("t1 clr_cnt%0d", i), int'(cnt_ns), exp_cnt[i]);
      check($sformatf("t1 clr_dw%0d", i), int'(dont_walk_ns), exp_dw[i]);
      check($sformatf("t1 clr_ew%0d", i), int'(walk_ew), 0);
      step();
    end
    check("t1 done st", int'(dbg_state_ns), S_DONE);
    check("t1 done dw", int'(dont_walk_ns), 1);
    check("t1 done cnt", int'(cnt_ns), 0);
    step();
    check("t1 done hold", int'(dbg_state_ns), S_DONE);

    // Press while NS is red: latched, served when the window opens.
    ns_light = RED;
    step();
    check("t2 idle", int'(dbg_state_ns), S_IDLE);
    ped_btn_ns = 1'b1;
    step();
    ped_btn_ns = 1'b0;
    step();
    step();
    check("t2 no walk", int'(walk_ns), 0);
    check("t2 req held", int'(dbg_req_ns), 1);
    ns_light = GRN;
    step();
    check("t2 walk", int'(walk_ns), 1);
    check("t2 req clr", int'(dbg_req_ns), 0);

    // Abort: NS yellow on WALK cycle 3.
    step();
    step();
    check("t3 walk c3", int'(walk_ns), 1);
    ns_light = YEL;
    step();
    check("t3 walk", int'(walk_ns), 0);
    check("t3 dw", int'(dont_walk_ns), 1);
    check("t3 cnt", int'(cnt_ns), 0);
    check("t3 st", int'(dbg_state_ns), S_IDLE);
    check("t3 fault", int'(fault), 0);

    // Press during WALK: no second walk in the same green.
    ns_light = RED;
    step();
    ns_light   = GRN;
    ped_btn_ns = 1'b1;
    step();
    ped_btn_ns = 1'b0;
    step();
    check("t4 walk", int'(walk_ns), 1);
    ped_btn_ns = 1'b1;
    step();
    ped_btn_ns = 1'b0;
    check("t4 req in walk", int'(dbg_req_ns), 1);
    repeat (13) step();
    check("t4 done", int'(dbg_state_ns), S_DONE);
    check("t4 req kept", int'(dbg_req_ns), 1);
    repeat (5) step();
    check("t4 still done", int'(dbg_state_ns), S_DONE);
    check("t4 no 2nd walk", int'(walk_ns), 0);
    ns_light = YEL;
    step();
    check("t4 leave done", int'(dbg_state_ns), S_IDLE);
    ns_light = RED;
    step();
    ns_light = GRN;
    step();
    check("t4 next green walk", int'(walk_ns), 1);
    check("t4 req served", int'(dbg_req_ns), 0);

    // Fault: non-one-hot light while walking.
    ns_light = 3'b011;
    step();
    check("t5a fault", int'(fault), 1);
    check("t5a st", int'(dbg_state_ns), S_IDLE);
    check_idle_all("t5a");
    ns_light   = GRN;
    ped_btn_ns = 1'b1;
    ped_btn_ew = 1'b1;
    repeat (3) step();
    ped_btn_ns = 1'b0;
    ped_btn_ew = 1'b0;
    check("t5a sticky", int'(fault), 1);
    check("t5a req_ns", int'(dbg_req_ns), 0);
    check("t5a req_ew", int'(dbg_req_ew), 0);
    check_idle_all("t5a legal");
    do_reset();
    check("t5 rst fault", int'(fault), 0);

    // Fault: both green.
    ns_light = GRN;
    ew_light = GRN;
    step();
    check("t5b fault", int'(fault), 1);
    ew_light = RED;
    step();
    check("t5b sticky", int'(fault), 1);
    check_idle_all("t5b");
    do_reset();

    // EW channel walks on its own window.
    ns_light   = RED;
    ew_light   = GRN;
    ped_btn_ew = 1'b1;
    step();
    ped_btn_ew = 1'b0;
    step();
    check("t7 walk_ew", int'(walk_ew), 1);
    check("t7 walk_ns", int'(walk_ns), 0);
    check("t7 dw_ew", int'(dont_walk_ew), 0);
    ew_light = RED;
    step();
    check("t7 abort ew", int'(walk_ew), 0);

    // Reset mid-CLEAR.
    ns_light   = GRN;
    ped_btn_ns = 1'b1;
    step();
    ped_btn_ns = 1'b0;
    step();
    repeat (8) step();
    check("t6 clr cnt", int'(cnt_ns), 6);
    ped_btn_ew = 1'b1;
    step();
    ped_btn_ew = 1'b0;
    check("t6 clr cnt2", int'(cnt_ns), 5);
    check("t6 req_ew", int'(dbg_req_ew), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_all("t6 rst");
    check("t6 fault", int'(fault), 0);
    check("t6 req_ns", int'(dbg_req_ns), 0);
    check("t6 req_ew", int'(dbg_req_ew), 0);
    check("t6 st_ns", int'(dbg_state_ns), S_IDLE);
    check("t6 st_ew", int'(dbg_state_ew), S_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian signal stage downstream of the 4-way traffic light controller. It consumes the registered `ns_light`/`ew_light` vectors and drives WALK / DON'T WALK heads and a clearance countdown for two crosswalks: NS, parallel to north-south traffic, and EW, parallel to east-west traffic. It latches push-button requests and grants a walk phase only inside a safe parallel-green window. It flags illegal light combinations as a sticky fault.

## Interface
Parameters:
- `WALK_CYC`, default 8: walk-phase length in cycles (≥1).
- `CLEAR_CYC`, default 6: flashing-clearance length in cycles (1..255).
- `FLASH_DIV`, default 2: cycles per flash half-period during clearance (≥1).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `ns_light`  in  3  NS vehicle light, one-hot: [2]=RED, [1]=YELLOW, [0]=GREEN.
- `ew_light`  in  3  EW vehicle light, same encoding.
- `ped_btn_ns`  in  1  NS crosswalk button, level, already synchronised.
- `ped_btn_ew`  in  1  EW crosswalk button.
- `walk_ns`, `walk_ew`  out  1  WALK head on.
- `dont_walk_ns`, `dont_walk_ew`  out  1  DON'T WALK head on; flashes during clearance.
- `cnt_ns`, `cnt_ew`  out  8  remaining clearance cycles; 0 outside clearance.
- `fault`  out  1  sticky illegal-light flag.

## Operation
- All outputs are registered. Reset values: walk=0, dont_walk=1, cnt=0, fault=0, request latches=0, both channel FSMs in IDLE.
- Each channel is an identical FSM. The "parallel" light is `ns_light` for NS and `ew_light` for EW. The "cross" light is the other one.
- Safe window: parallel==3'b001 (GREEN) and cross==3'b100 (RED).
- Request latch `req_x`:
  - Set on any edge where the button is 1.
  - Cleared on the edge that enters WALK.
  - If the button is 1 on that same edge, set wins.
  - Presses during WALK, CLEAR or DONE stay latched and are served in the next safe window.
- FSM states:
  - IDLE: walk=0, dont_walk=1 steady. Goes to WALK when req_x=1 and the window is safe.
  - WALK: walk=1, dont_walk=0. Goes to CLEAR after exactly WALK_CYC cycles.
  - CLEAR: walk=0. dont_walk=1 for the first FLASH_DIV cycles, then toggles every FLASH_DIV cycles. cnt shows CLEAR_CYC on the first CLEAR cycle and decrements to 1 on the last. Goes to DONE after exactly CLEAR_CYC cycles.
  - DONE: walk=0, dont_walk=1 steady, cnt=0. Goes to IDLE on the first edge where parallel≠GREEN. This blocks a second walk in the same green.
- Abort: in WALK or CLEAR, if the window becomes unsafe, the FSM goes to IDLE on that edge. The next cycle shows walk=0, dont_walk=1 steady, cnt=0. req_x is untouched.
- Fault condition, evaluated every edge:
  - either light vector is not one-hot, or
  - both lights are non-RED at the same time.
- Fault response: on the edge where the condition is seen, `fault`←1 and stays 1 until reset. While `fault`=1:
  - both FSMs are held in IDLE;
  - both latches are held at 0;
  - walk=0, dont_walk=1, cnt=0;
  - button presses are ignored.
- Reset mid-operation returns every register to its reset value on that edge, regardless of state.

## Timing
- Button→latch: 1 edge. Latch→WALK: 1 edge. With the window already safe, walk rises 2 cycles after the cycle the button is first sampled high.
- WALK lasts exactly WALK_CYC cycles; CLEAR lasts exactly CLEAR_CYC cycles; the walk phase and the clearance never overlap.
- Unsafe light→walk/dont_walk change: 1 cycle, for both abort and fault.
- The flash phase counter restarts at each CLEAR entry; dont_walk at CLEAR entry is always 1.
- The two channels are independent. Simultaneous requests are legal; the safe-window rule makes the two walk phases mutually exclusive.

## Test plan
- Reset, then ns=GREEN/ew=RED with ped_btn_ns pulsed 1 cycle. Required: walk_ns high 2 cycles later for 8 cycles. Then 6 CLEAR cycles with cnt_ns 6,5,4,3,2,1 and dont_walk_ns 1,1,0,0,1,1. Then DONE. walk_ew stays 0 throughout.
- Button pressed while ns=RED. Required: latched, no walk. walk_ns rises 1 cycle after ns turns GREEN with ew RED. Latch clears on WALK entry.
- NS WALK active, ns switches to YELLOW on WALK cycle 3. Required: next cycle walk_ns=0, dont_walk_ns=1, cnt_ns=0; FSM is in IDLE.
- Press during WALK. Required: no second walk in the same green; DONE holds until ns leaves GREEN; walk is served in the next green.
- ns=3'b011, then a separate case with ns=GREEN and ew=GREEN. Required: fault=1 the next cycle and stays 1 after the lights become legal; all walk=0 and dont_walk=1; buttons ignored until reset.
- Reset asserted mid-CLEAR. Required: next cycle all outputs at reset values and latches cleared.
